// File: rtl/mod_counter_ctrl_pkg.sv
// Shared state encoding for the modulo-counter run-control sequencer.
// The localparams fix the encoding and the enum gives it readable names.
package mod_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_RUN   = S_RUN,
        ST_PAUSE = S_PAUSE,
        ST_DONE  = S_DONE
    } ctrl_state_e;

endpackage

// File: rtl/mod_counter_ctrl_if.sv
// Register/command and status bundle between a host and mod_counter_ctrl.
// The host uses the master modport and the sequencer uses the slave modport.
interface mod_counter_ctrl_if #(
    parameter int BITS     = 4,
    parameter int RPT_BITS = 8
);

    logic                cfg_we;
    logic [BITS-1:0]     cfg_term;
    logic [RPT_BITS-1:0] cfg_rpt;
    logic                start;
    logic                pause;
    logic                stop;
    logic [BITS-1:0]     count;
    logic                busy;
    logic                paused;
    logic                tick;
    logic                done;
    logic                cfg_err;

    modport master (
        output cfg_we, cfg_term, cfg_rpt, start, pause, stop,
        input  count, busy, paused, tick, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_term, cfg_rpt, start, pause, stop,
        output count, busy, paused, tick, done, cfg_err
    );

endinterface

// File: rtl/prog_mod_counter.sv
// Programmable modulo counter: counts 0..term when enabled, clr forces 0.
// wrap flags that the count sits at term, so the next enabled edge loads 0.
module prog_mod_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            en,
    input  logic [BITS-1:0] term,
    output logic [BITS-1:0] q,
    output logic            wrap
);

    logic [BITS-1:0] q_q;
    logic [BITS-1:0] q_d;

    assign wrap = (q_q == term);
    assign q    = q_q;

    // NOTE: next-state logic assigns its default first so no path can hold a value and infer a latch.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = wrap ? '0 : q_q + BITS'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run-control sequencer for prog_mod_counter: config shadows, start/pause/stop,
// wrap tick and end-of-run done. Define AUTO_RESTART_EN to loop runs until stop.
module mod_counter_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int RPT_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mod_counter_ctrl_if.slave      bus
);

    ctrl_state_e         state_q;
    ctrl_state_e         state_d;
    logic [BITS-1:0]     term_q;
    logic [RPT_BITS-1:0] rpt_q;
    logic [RPT_BITS-1:0] wrap_cnt_q;
    logic [RPT_BITS-1:0] wrap_cnt_d;
    logic                cfg_err_q;
    logic                cfg_err_d;
    logic                cfg_ok;

    logic                cnt_clr;
    logic                cnt_en;
    logic [BITS-1:0]     cnt_q;
    logic                at_term;
    logic                last_wrap;
    logic                tick;
    logic                done;

    prog_mod_counter #(
        .BITS(BITS)
    ) u_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .term   (term_q),
        .q      (cnt_q),
        .wrap   (at_term)
    );

    // The wrap about to happen is the one that completes a bounded run.
    assign last_wrap = (rpt_q != '0) && ((wrap_cnt_q + RPT_BITS'(1)) == rpt_q);

    always_comb begin
        state_d    = state_q;
        wrap_cnt_d = wrap_cnt_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        tick       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start) begin
                    state_d    = ST_RUN;
                    wrap_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (at_term && (last_wrap || !bus.pause)) begin
                    // Completion outranks a coincident pause.
                    tick       = 1'b1;
                    cnt_en     = 1'b1;
                    wrap_cnt_d = wrap_cnt_q + RPT_BITS'(1);
                    if (last_wrap) begin
                        state_d = ST_DONE;
                    end
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                done = 1'b1;
`ifdef AUTO_RESTART_EN
                // Counter already sits at 0 here; advancing keeps the sequence gapless.
                state_d    = ST_RUN;
                wrap_cnt_d = '0;
                cnt_en     = 1'b1;
`else
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    assign cfg_ok    = bus.cfg_we && (state_q == ST_IDLE) && (bus.cfg_term != '0);
    assign cfg_err_d = bus.cfg_we && !cfg_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            term_q     <= '1;
            rpt_q      <= '0;
            wrap_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrap_cnt_q <= wrap_cnt_d;
            cfg_err_q  <= cfg_err_d;
            if (cfg_ok) begin
                term_q <= bus.cfg_term;
                rpt_q  <= bus.cfg_rpt;
            end
        end
    end

    assign bus.count   = cnt_q;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.paused  = (state_q == ST_PAUSE);
    assign bus.tick    = tick;
    assign bus.done    = done;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Bench for mod_counter_ctrl: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a behavioural run model.
module tb_mod_counter_ctrl;

    localparam int BITS     = 4;
    localparam int RPT_BITS = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mod_counter_ctrl_if #(.BITS(BITS), .RPT_BITS(RPT_BITS)) bus ();

    mod_counter_ctrl #(.BITS(BITS), .RPT_BITS(RPT_BITS)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run phase plus plain integer counters.
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_END} m_phase_e;
    m_phase_e m_phase = M_IDLE;
    int m_count = 0;
    int m_term  = (1 << BITS) - 1;
    int m_rpt   = 0;
    int m_wraps = 0;
    bit m_err   = 1'b0;

    function automatic bit m_final();
        return (m_rpt != 0) && (m_wraps + 1 == m_rpt);
    endfunction

    function automatic bit m_tick_now();
        return (m_phase == M_RUN) && !bus.stop && (m_count == m_term) && (!bus.pause || m_final());
    endfunction

    initial forever begin
        bit t;
        bit fin;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_phase = M_IDLE;
            m_count = 0;
            m_term  = (1 << BITS) - 1;
            m_rpt   = 0;
            m_wraps = 0;
            m_err   = 1'b0;
        end else begin
            t   = m_tick_now();
            fin = m_final();
            if (bus.cfg_we && m_phase == M_IDLE && bus.cfg_term != 0) begin
                m_term = int'(bus.cfg_term);
                m_rpt  = int'(bus.cfg_rpt);
                m_err  = 1'b0;
            end else begin
                m_err = bus.cfg_we;
            end
            case (m_phase)
                M_IDLE: begin
                    m_count = 0;
                    if (bus.start) begin
                        m_phase = M_RUN;
                        m_wraps = 0;
                    end
                end
                M_RUN: begin
                    if (bus.stop) begin
                        m_phase = M_IDLE;
                        m_count = 0;
                    end else if (t) begin
                        m_count = 0;
                        m_wraps = (m_wraps + 1) % (1 << RPT_BITS);
                        if (fin) m_phase = M_END;
                    end else if (bus.pause) begin
                        m_phase = M_HOLD;
                    end else begin
                        m_count = m_count + 1;
                    end
                end
                M_HOLD: begin
                    if (bus.stop) begin
                        m_phase = M_IDLE;
                        m_count = 0;
                    end else if (!bus.pause) begin
                        m_phase = M_RUN;
                    end
                end
                default: begin
                    m_phase = M_IDLE;
                    m_count = 0;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("model_count",   32'(bus.count),   32'(m_count));
            check("model_busy",    32'(bus.busy),    32'(m_phase == M_RUN || m_phase == M_HOLD));
            check("model_paused",  32'(bus.paused),  32'(m_phase == M_HOLD));
            check("model_tick",    32'(bus.tick),    32'(m_tick_now()));
            check("model_done",    32'(bus.done),    32'(m_phase == M_END));
            check("model_cfg_err", 32'(bus.cfg_err), 32'(m_err));
        end
    end

    task automatic drive(input bit s, input bit p, input bit stp, input bit we, input int t, input int r);
        @(posedge clk);
        #1;
        bus.start    = s;
        bus.pause    = p;
        bus.stop     = stp;
        bus.cfg_we   = we;
        bus.cfg_term = t[BITS-1:0];
        bus.cfg_rpt  = r[RPT_BITS-1:0];
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    int exp2_cnt  [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    int exp2_tick [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int exp2_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp2_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        int n_tick;
        int n_done;
        bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_term = '0; bus.cfg_rpt = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_on = 1'b1;

        // Asynchronous reset in the middle of a run.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (6) idle();
        check("rst_pre_count", 32'(bus.count), 32'd5);
        reset_n = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // T=3, two wraps per run.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            idle();
            check($sformatf("t2_count[%0d]", i), 32'(bus.count), 32'(exp2_cnt[i]));
            check($sformatf("t2_tick[%0d]", i),  32'(bus.tick),  32'(exp2_tick[i]));
            check($sformatf("t2_done[%0d]", i),  32'(bus.done),  32'(exp2_done[i]));
            check($sformatf("t2_busy[%0d]", i),  32'(bus.busy),  32'(exp2_busy[i]));
        end

        // Free-run T=12 for 40 cycles, then stop.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        n_tick = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (bus.tick) begin
                n_tick++;
                check("t3_tick_count", 32'(bus.count), 32'd12);
            end
            if (bus.done) n_done++;
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        if (bus.tick) n_tick++;
        if (bus.done) n_done++;
        idle();
        if (bus.done) n_done++;
        check("t3_ticks", 32'(n_tick), 32'd3);
        check("t3_dones", 32'(n_done), 32'd0);
        check("t3_stop_count", 32'(bus.count), 32'd0);
        check("t3_stop_busy",  32'(bus.busy),  32'd0);

        // Pause held at count=2, T=3, one wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle();
        idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("t4_enter_count", 32'(bus.count), 32'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            check("t4_hold_paused", 32'(bus.paused), 32'd1);
            check("t4_hold_count",  32'(bus.count),  32'd2);
        end
        idle();
        check("t4_rel_paused", 32'(bus.paused), 32'd1);
        idle();
        check("t4_resume_count", 32'(bus.count), 32'd2);
        idle();
        check("t4_term_count", 32'(bus.count), 32'd3);
        check("t4_term_tick",  32'(bus.tick),  32'd1);
        idle();
        check("t4_done", 32'(bus.done), 32'd1);

        // Illegal term in IDLE, write while running.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 5);
        idle();
        check("t5_err_idle", 32'(bus.cfg_err), 32'd1);
        idle();
        check("t5_err_clear", 32'(bus.cfg_err), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7, 9);
        idle();
        check("t5_err_run",   32'(bus.cfg_err), 32'd1);
        check("t5_run_count", 32'(bus.count),   32'd2);
        idle();
        check("t5_term_tick", 32'(bus.tick), 32'd1);
        idle();
        check("t5_done", 32'(bus.done), 32'd1);

        // Final tick together with pause, then together with stop.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("t6_pause_tick", 32'(bus.tick), 32'd1);
        idle();
        check("t6_pause_done",   32'(bus.done),   32'd1);
        check("t6_pause_paused", 32'(bus.paused), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("t6_stop_tick", 32'(bus.tick), 32'd0);
        idle();
        check("t6_stop_done",  32'(bus.done),  32'd0);
        check("t6_stop_busy",  32'(bus.busy),  32'd0);
        check("t6_stop_count", 32'(bus.count), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 19) == 0,
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)));
        end

        idle();
        @(posedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
